// File: rtl/shift_pkg.sv
// Shared encodings for the pipelined shifter: instruction op codes and the
// reduced shift class carried down the pipeline.
package shift_pkg;

    typedef enum logic [2:0] {
        SHOP_SLL  = 3'b000,
        SHOP_SRL  = 3'b001,
        SHOP_SRA  = 3'b010,
        SHOP_ROTR = 3'b011,
        SHOP_ROTL = 3'b100,
        SHOP_LUI  = 3'b101,
        SHOP_PASS = 3'b110
    } shop_e;

    // Every op reduces to one of these; ROTL becomes ROR, LUI/PASS become LEFT.
    typedef enum logic [1:0] {
        CLS_LEFT = 2'b00,
        CLS_SRL  = 2'b01,
        CLS_SRA  = 2'b10,
        CLS_ROR  = 2'b11
    } shcls_e;

endpackage

// File: rtl/shift_stage.sv
// Combinational partial barrel shift: resolves NBITS amount bits whose
// lowest bit has weight 2^OFFSET, for one shift class.
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NBITS  = 3,
    parameter int unsigned OFFSET = 2
) (
    input  logic [WIDTH-1:0] value,
    input  shcls_e           cls,
    input  logic             sign,
    input  logic [NBITS-1:0] amt,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] chain [0:NBITS];

    assign chain[0] = value;

    for (genvar i = 0; i < NBITS; i++) begin : g_step
        localparam int unsigned K = 1 << (OFFSET + i);
        // Sign fill uses the operand's original MSB, not the partially shifted one.
        localparam logic [WIDTH-1:0] SFILL = ~({WIDTH{1'b1}} >> K);

        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] srl;
        logic [WIDTH-1:0] step;

        assign cur = chain[i];
        assign srl = cur >> K;

        always_comb begin
            case (cls)
                CLS_LEFT: step = cur << K;
                CLS_SRL:  step = srl;
                CLS_SRA:  step = sign ? (srl | SFILL) : srl;
                default:  step = srl | (cur << (WIDTH - K));
            endcase
        end

        assign chain[i+1] = amt[i] ? step : cur;
    end

    assign result = chain[NBITS];

endmodule

// File: rtl/pipe_shifter.sv
// Two-stage pipelined barrel shifter with valid/ready handshake and a tag
// that travels alongside each operation.
module pipe_shifter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH),
    parameter int unsigned SPLIT = SHW - 2,
    parameter int unsigned TAGW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_amtsel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAGW-1:0]  out_tag,
    output logic             out_zero
);

    localparam int unsigned LOW = SHW - SPLIT;
    localparam logic [SHW-1:0] HALF = SHW'(WIDTH / 2);

    logic             v1;
    logic             v2;
    logic             adv2;
    logic             accept;

    logic [SHW-1:0]   amt;
    logic [SHW-1:0]   d_amt;
    shcls_e           d_cls;
    logic [WIDTH-1:0] s1_next;
    logic [WIDTH-1:0] s2_next;
    logic             s2_zero;

    shcls_e           s1_cls;
    logic             s1_sign;
    logic [WIDTH-1:0] s1_val;
    logic [LOW-1:0]   s1_amt;
    logic [TAGW-1:0]  s1_tag;

    logic             unused_a;

    assign unused_a = ^in_a[WIDTH-1:SHW];

    // Handshake: out_ready feeds in_ready combinationally so a full pipe still streams.
    assign adv2      = !v2 || out_ready;
    assign in_ready  = !v1 || adv2;
    assign accept    = in_valid && in_ready;
    assign out_valid = v2;

    assign amt = in_amtsel ? in_shamt : in_a[SHW-1:0];

    always_comb begin
        d_cls = CLS_LEFT;
        d_amt = amt;
        case (in_op)
            SHOP_SLL:  d_cls = CLS_LEFT;
            SHOP_SRL:  d_cls = CLS_SRL;
            SHOP_SRA:  d_cls = CLS_SRA;
            SHOP_ROTR: d_cls = CLS_ROR;
            SHOP_ROTL: begin
                // Left rotate by n equals right rotate by (WIDTH - n) mod WIDTH.
                d_cls = CLS_ROR;
                d_amt = '0 - amt;
            end
            SHOP_LUI:  d_amt = HALF;
            default:   d_amt = '0;
        endcase
    end

    shift_stage #(
        .WIDTH  (WIDTH),
        .NBITS  (SPLIT),
        .OFFSET (LOW)
    ) u_stage1 (
        .value  (in_b),
        .cls    (d_cls),
        .sign   (in_b[WIDTH-1]),
        .amt    (d_amt[SHW-1:LOW]),
        .result (s1_next)
    );

    shift_stage #(
        .WIDTH  (WIDTH),
        .NBITS  (LOW),
        .OFFSET (0)
    ) u_stage2 (
        .value  (s1_val),
        .cls    (s1_cls),
        .sign   (s1_sign),
        .amt    (s1_amt),
        .result (s2_next)
    );

    assign s2_zero = (s2_next == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1      <= 1'b0;
            s1_cls  <= CLS_LEFT;
            s1_sign <= 1'b0;
            s1_val  <= '0;
            s1_amt  <= '0;
            s1_tag  <= '0;
        end else begin
            if (accept) begin
                v1      <= 1'b1;
                s1_cls  <= d_cls;
                s1_sign <= in_b[WIDTH-1];
                s1_val  <= s1_next;
                s1_amt  <= d_amt[LOW-1:0];
                s1_tag  <= in_tag;
            end else if (adv2) begin
                v1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2         <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_zero   <= 1'b1;
        end else begin
            if (v1 && adv2) begin
                v2         <= 1'b1;
                out_result <= s2_next;
                out_tag    <= s1_tag;
                out_zero   <= s2_zero;
            end else if (adv2) begin
                v2 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter: expected results are queued on accept
// and compared as each result leaves the pipeline.
module tb_pipe_shifter;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;
    localparam int TAGW  = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic             in_amtsel;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [SHW-1:0]   in_shamt;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAGW-1:0]  out_tag;
    logic             out_zero;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [TAGW-1:0]  tag;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    int stalls = 0;
    bit stop_bp = 1'b0;

    pipe_shifter #(
        .WIDTH (WIDTH),
        .TAGW  (TAGW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_amtsel  (in_amtsel),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_shamt   (in_shamt),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_zero   (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_shift(input logic [2:0] op, input logic [4:0] amt,
                                                   input logic [WIDTH-1:0] b);
        logic [5:0] inv;
        inv = 6'd32 - {1'b0, amt};
        case (op)
            3'd0:    return b << amt;
            3'd1:    return b >> amt;
            3'd2:    return WIDTH'($signed(b) >>> amt);
            3'd3:    return (b >> amt) | (b << inv);
            3'd4:    return (b << amt) | (b >> inv);
            3'd5:    return b << 16;
            default: return b;
        endcase
    endfunction

    // A result is consumed at the next rising edge whenever valid & ready hold here.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_out++;
            if (sbq.size() == 0) begin
                check("unexpected_out", out_valid, 1'b0);
            end else begin
                mon_e = sbq.pop_front();
                check("result", out_result, mon_e.res);
                check("tag", out_tag, mon_e.tag);
                check("zero", out_zero, mon_e.res == '0);
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic sel, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [4:0] sh, input logic [4:0] tag);
        logic [4:0] amt;
        exp_t       e;
        bit         accepted;
        amt       = sel ? sh : a[4:0];
        accepted  = 1'b0;
        in_valid  = 1'b1;
        in_op     = op;
        in_amtsel = sel;
        in_a      = a;
        in_b      = b;
        in_shamt  = sh;
        in_tag    = tag;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.res = ref_shift(op, amt, b);
                e.tag = tag;
                sbq.push_back(e);
                accepted = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        if (!accepted) check("send_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", sbq.size(), 0);
    endtask

    task automatic send_random(input logic [4:0] tag);
        send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom,
             5'($urandom_range(0, 31)), tag);
    endtask

    initial begin
        int n0;
        logic [WIDTH-1:0] held;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_amtsel = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_shamt  = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        #12;
        check("rst_valid", out_valid, 1'b0);
        check("rst_result", out_result, 0);
        check("rst_tag", out_tag, 0);
        check("rst_zero", out_zero, 1'b1);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed ops, first one also checks the two-cycle latency.
        send(3'd0, 1'b1, 32'h0, 32'h0000_00F1, 5'd4, 5'd1);
        check("lat_cycle1", out_valid, 1'b0);
        @(posedge clk);
        #1;
        check("lat_cycle2", out_valid, 1'b1);
        send(3'd2, 1'b0, 32'hFFFF_FFE8, 32'h8000_1234, 5'd0, 5'd2);
        send(3'd1, 1'b0, 32'hFFFF_FFE8, 32'h8000_1234, 5'd0, 5'd3);
        send(3'd3, 1'b1, 32'h0, 32'h0000_0001, 5'd1, 5'd4);
        send(3'd4, 1'b1, 32'h0, 32'h1234_5678, 5'd0, 5'd5);
        send(3'd5, 1'b1, 32'h1F, 32'h0000_ABCD, 5'd7, 5'd6);
        send(3'd6, 1'b1, 32'h0, 32'hDEAD_BEEF, 5'd9, 5'd7);
        send(3'd7, 1'b0, 32'h3, 32'hCAFE_F00D, 5'd0, 5'd8);
        send(3'd0, 1'b1, 32'h0, 32'h8000_0000, 5'd1, 5'd9);
        send(3'd4, 1'b0, 32'h3, 32'h8000_0001, 5'd0, 5'd10);
        send(3'd2, 1'b1, 32'h0, 32'h8000_0000, 5'd31, 5'd11);
        send(3'd3, 1'b1, 32'h0, 32'h8765_4321, 5'd31, 5'd12);
        drain();

        // Back-to-back streaming.
        stalls = 0;
        n0 = n_out;
        for (int t = 0; t < 16; t++) send_random(5'(t));
        check("stream_stalls", stalls, 0);
        drain();
        check("stream_count", n_out - n0, 16);

        // Backpressure: two ops fill the pipe.
        out_ready = 1'b0;
        n0 = n_out;
        send(3'd0, 1'b1, 32'h0, 32'h0000_0003, 5'd5, 5'd20);
        send(3'd1, 1'b1, 32'h0, 32'hF000_0000, 5'd6, 5'd21);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_valid", out_valid, 1'b1);
        held = out_result;
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_result", out_result, held);
        check("bp_hold_tag", out_tag, 5'd20);
        check("bp_still_full", in_ready, 1'b0);
        out_ready = 1'b1;
        drain();
        check("bp_count", n_out - n0, 2);

        // Random backpressure while streaming.
        fork
            begin
                while (!stop_bp) begin
                    @(posedge clk);
                    #1;
                    if (!stop_bp) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        n0 = n_out;
        for (int t = 0; t < 30; t++) send_random(5'(t));
        stop_bp = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        check("rbp_count", n_out - n0, 30);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(3'd0, 1'b1, 32'h0, 32'h0000_0001, 5'd3, 5'd25);
        send(3'd3, 1'b1, 32'h0, 32'h0000_00FF, 5'd4, 5'd26);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_result", out_result, 0);
        check("mid_rst_tag", out_tag, 0);
        check("mid_rst_zero", out_zero, 1'b1);
        check("mid_rst_in_ready", in_ready, 1'b1);
        sbq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        send(3'd2, 1'b1, 32'h0, 32'h8000_00F0, 5'd4, 5'd30);
        drain();
        check("post_rst_count", n_out - n0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
